thermal_dfs_ctrl: RTL

Parametrised dynamic-frequency-scaling controller for the 32-bit RISC core's thermal management unit. It samples an N-level temperature state and debounces it with hysteresis. It produces a clock-enable pulse train whose period is looked up per level or forced by a software override. Divisor changes take effect only on period boundaries, so the pipeline never sees a truncated or stretched slot. It sits between the thermal sensor interface and the core's pipeline-advance enable.

---
 rtl/thermal_dfs_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/thermal_dfs_ctrl.sv
// Thermal DFS controller: synchronises and debounces a temperature level with
// asymmetric hysteresis, then paces the pipeline with a clock-enable pulse train.
module thermal_dfs_ctrl #(
   parameter int TEMP_W = 3,
   parameter int DIV_W  = 4,
   parameter int DWELL  = 16,
   parameter logic [(2**TEMP_W)*DIV_W-1:0] DIV_TABLE = 32'h00F8_8421
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TEMP_W-1:0] temp_st,
   input  logic              override_en,
   input  logic [DIV_W-1:0]  override_div,
   output logic              clk_en,
   output logic [TEMP_W-1:0] cur_level,
   output logic [DIV_W-1:0]  cur_div,
   output logic              level_chg,
   output logic              throttled,
   output logic              stopped
);

   localparam int                CNT_W     = $clog2(2*DWELL);
   localparam logic [CNT_W-1:0]  ESC_CNT   = CNT_W'(DWELL-1);
   localparam logic [CNT_W-1:0]  DESC_CNT  = CNT_W'(2*DWELL-1);
   localparam logic [DIV_W-1:0]  RESET_DIV = DIV_TABLE[DIV_W-1:0];

   logic [TEMP_W-1:0] s1_q, s1_d, s2_q, s2_d, cand_q, cand_d;
   logic [TEMP_W-1:0] cur_level_q, cur_level_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  phase_q, phase_d, cur_div_q, cur_div_d;
   logic              clk_en_q, clk_en_d, level_chg_q, level_chg_d;

   logic [DIV_W-1:0]  table_div, target_div, last_phase;
   logic              accept;

   assign table_div  = DIV_TABLE[int'(cur_level_q)*DIV_W +: DIV_W];
   assign target_div = override_en ? override_div : table_div;
   assign last_phase = cur_div_q - 1'b1;

   // Escalation needs DWELL stable cycles, de-escalation twice that.
   assign accept = ((cand_q > cur_level_q) && (cnt_q == ESC_CNT)) ||
                   ((cand_q < cur_level_q) && (cnt_q == DESC_CNT));

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      s1_d        = temp_st;
      s2_d        = s1_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      cur_level_d = accept ? cand_q : cur_level_q;
      level_chg_d = accept;
      phase_d     = phase_q;
      cur_div_d   = cur_div_q;
      clk_en_d    = 1'b0;

      if (s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = '0;
      end else if (cnt_q != DESC_CNT) begin
         cnt_d = cnt_q + 1'b1;
      end

      // Divisor only changes on a period boundary, or at once while stopped.
      if (cur_div_q == '0) begin
         phase_d   = '0;
         cur_div_d = target_div;
      end else if (phase_q == last_phase) begin
         phase_d   = '0;
         clk_en_d  = 1'b1;
         cur_div_d = target_div;
      end else begin
         phase_d = phase_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         s1_q        <= '0;
         s2_q        <= '0;
         cand_q      <= '0;
         cnt_q       <= '0;
         cur_level_q <= '0;
         level_chg_q <= 1'b0;
         phase_q     <= '0;
         cur_div_q   <= RESET_DIV;
         clk_en_q    <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         cur_level_q <= cur_level_d;
         level_chg_q <= level_chg_d;
         phase_q     <= phase_d;
         cur_div_q   <= cur_div_d;
         clk_en_q    <= clk_en_d;
      end
   end

   assign clk_en    = clk_en_q;
   assign cur_level = cur_level_q;
   assign cur_div   = cur_div_q;
   assign level_chg = level_chg_q;
   assign throttled = (cur_div_q != DIV_W'(1));
   assign stopped   = (cur_div_q == '0);

endmodule
